// File: rtl/pixel_window_gen.sv
// Raster-to-window converter: buffers one IMG_DIM x IMG_DIM image, then emits
// every 2x2 window {TL, TR, BL, BR} over a valid/ready handshake.
module pixel_window_gen #(
    parameter int IMG_DIM = 3,
    parameter int PIX_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               pix_sof,
    output logic               pix_ready,
    output logic [4*PIX_W-1:0] pixels,
    output logic               win_valid,
    input  logic               win_ready,
    output logic               win_last,
    output logic               frame_err
);

    localparam int N      = IMG_DIM * IMG_DIM;
    localparam int M      = IMG_DIM - 1;
    localparam int W      = M * M;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int WIDX_W = $clog2(W + 1);
    localparam int IDX_W  = $clog2(N);
    localparam int COL_W  = $clog2(M + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(W - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(M - 1);
    localparam logic [IDX_W-1:0]  OFF_TR    = IDX_W'(1);
    localparam logic [IDX_W-1:0]  OFF_BL    = IDX_W'(IMG_DIM);
    localparam logic [IDX_W-1:0]  OFF_BR    = IDX_W'(IMG_DIM + 1);

    // IDLE is the single post-reset cycle in which pix_ready stays low.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDX_W-1:0]  widx_q, widx_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic               synced_q, synced_d;
    logic               frame_err_q, frame_err_d;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   idx_tr, idx_bl, idx_br;

    logic [PIX_W-1:0]   pix_buf_q [N];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        col_d       = col_q;
        addr_d      = addr_q;
        synced_d    = synced_q;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = IDX_W'(cnt_q);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
            ST_LOAD: begin
                if (pix_valid) begin
                    if (pix_sof) begin
                        // A start-of-frame always restarts the image at buf[0].
                        wr_en       = 1'b1;
                        wr_idx      = '0;
                        cnt_d       = CNT_W'(1);
                        synced_d    = 1'b1;
                        frame_err_d = (cnt_q != '0);
                    end else if (synced_q) begin
                        wr_en = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_EMIT;
                            cnt_d   = '0;
                            widx_d  = '0;
                            col_d   = '0;
                            addr_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_EMIT: begin
                if (win_ready) begin
                    if (widx_q == WIDX_LAST) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        widx_d = widx_q + WIDX_W'(1);
                        // Stepping past the row end skips the last column's anchor.
                        if (col_q == COL_LAST) begin
                            col_d  = '0;
                            addr_d = addr_q + IDX_W'(2);
                        end else begin
                            col_d  = col_q + COL_W'(1);
                            addr_d = addr_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            widx_q      <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            synced_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            widx_q      <= widx_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            synced_q    <= synced_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pix_buf_q[wr_idx] <= pix_in;
        end
    end

    always_comb begin
        idx_tr    = addr_q + OFF_TR;
        idx_bl    = addr_q + OFF_BL;
        idx_br    = addr_q + OFF_BR;
        pix_ready = (state_q == ST_LOAD);
        win_valid = (state_q == ST_EMIT);
        win_last  = win_valid && (widx_q == WIDX_LAST);
        frame_err = frame_err_q;
        pixels    = '0;
        if (win_valid) begin
            pixels = {pix_buf_q[addr_q], pix_buf_q[idx_tr],
                      pix_buf_q[idx_bl], pix_buf_q[idx_br]};
        end
    end

endmodule

// File: tb/tb_pixel_window_gen.sv
// Bench for pixel_window_gen: directed image scenarios plus random frames, checked
// by an image-coordinate reference model through a window scoreboard.
module tb_pixel_window_gen;

    localparam int D = 3;
    localparam int N = D * D;
    localparam int M = D - 1;
    localparam int W = M * M;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [31:0] pixels;
    logic        win_valid;
    logic        win_ready;
    logic        win_last;
    logic        frame_err;

    pixel_window_gen #(.IMG_DIM(D), .PIX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .pixels    (pixels),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_last  (win_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] px;
        logic        last;
    } win_t;

    int          n_vec  = 0;
    int          n_fail = 0;
    win_t        exp_q [$];
    logic [31:0] got_q [$];
    logic [7:0]  frame [$];
    bit          synced      = 1'b0;
    bit          after_reset = 1'b0;
    bit          started     = 1'b0;
    bit          err_flag    = 1'b0;
    int          err_seen    = 0;
    int          rdy_mode    = 0;

    logic [7:0]  frm  [3][9] = '{
        '{8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01},
        '{8'h01, 8'hff, 8'hff, 8'hff, 8'h01, 8'hff, 8'hff, 8'hff, 8'h01},
        '{8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff}
    };
    logic [31:0] expw [3][4] = '{
        '{32'h01ffff01, 32'hff0101ff, 32'hff0101ff, 32'h01ffff01},
        '{32'h01ffff01, 32'hffff01ff, 32'hff01ffff, 32'h01ffff01},
        '{32'hff0101ff, 32'h01ffff01, 32'h01ffff01, 32'hff0101ff}
    };

    function automatic void chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out waiting, required DUT progress (t=%0t)", name, $time);
    endfunction

    // Pixel k sits at image row D-1-k/D, column D-1-k%D; windows scan rows top-down from row D-1.
    function automatic void build_windows();
        logic [7:0] img [D][D];
        win_t       w;
        for (int k = 0; k < N; k++) img[D-1-k/D][D-1-k%D] = frame[k];
        for (int wr = 0; wr < M; wr++) begin
            for (int wc = 0; wc < M; wc++) begin
                w.px   = {img[D-1-wr][D-1-wc], img[D-1-wr][D-2-wc],
                          img[D-2-wr][D-1-wc], img[D-2-wr][D-2-wc]};
                w.last = (wr == M-1) && (wc == M-1);
                exp_q.push_back(w);
            end
        end
    endfunction

    function automatic void model_accept(input logic [7:0] p, input logic sof);
        if (sof) begin
            if (frame.size() != 0) err_flag = 1'b1;
            frame.delete();
            frame.push_back(p);
            synced = 1'b1;
        end else if (synced) begin
            frame.push_back(p);
            if (frame.size() == N) begin
                build_windows();
                frame.delete();
            end
        end
    endfunction

    // Monitor: inputs change only just after posedge, so the negedge view equals what the next edge sees.
    always @(negedge clk) begin
        bit exp_valid;
        bit exp_ready;
        exp_valid = !after_reset && (exp_q.size() != 0);
        exp_ready = !after_reset && (exp_q.size() == 0);
        if (started) begin
            chk1("win_valid", win_valid, exp_valid);
            chk1("pix_ready", pix_ready, exp_ready);
            chk1("frame_err", frame_err, err_flag);
            if (after_reset) begin
                chk32("reset_pixels", pixels, 32'h0);
                chk1("reset_win_last", win_last, 1'b0);
            end
            if (win_valid && exp_valid) begin
                chk32("window", pixels, exp_q[0].px);
                chk1("win_last", win_last, exp_q[0].last);
                if (win_ready && rst) begin
                    got_q.push_back(pixels);
                    void'(exp_q.pop_front());
                end
            end
            if (frame_err) err_seen++;
        end
        err_flag = 1'b0;
        if (!rst) begin
            started     = 1'b1;
            after_reset = 1'b1;
            synced      = 1'b0;
            frame.delete();
            exp_q.delete();
        end else begin
            if (exp_ready && pix_valid) model_accept(pix_in, pix_sof);
            after_reset = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) win_ready = ($urandom_range(0, 3) != 0);
        else if (rdy_mode == 0) win_ready = 1'b1;
    end

    task automatic send_pix(input logic [7:0] p, input logic sof);
        int t = 0;
        pix_in    = p;
        pix_sof   = sof;
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && t < 300) begin
            t++;
            @(negedge clk);
        end
        if (!pix_ready) fail_timeout("pix_accept");
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int f);
        for (int i = 0; i < N; i++) send_pix(frm[f][i], i == 0);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || win_valid) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 1000) fail_timeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic check_windows(input string name, input int f);
        for (int i = 0; i < W; i++) begin
            if (got_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL %s[%0d]: got no window, required %h", name, i, expw[f][i]);
            end else begin
                chk32(name, got_q.pop_front(), expw[f][i]);
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int cnt;
        int e0;
        rst       = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // X image, preceded by two unsynchronised pixels that must be dropped.
        rdy_mode = 0;
        send_pix(8'h5a, 1'b0);
        send_pix(8'ha5, 1'b0);
        got_q.delete();
        send_frame(0);
        cnt = 0;
        @(negedge clk);
        chk1("first_window_latency", win_valid, 1'b1);
        if (win_valid) cnt++;
        repeat (W + 1) begin
            @(negedge clk);
            if (win_valid) cnt++;
        end
        chk32("x_valid_cycles", 32'(cnt), 32'(W));
        @(posedge clk);
        #1;
        check_windows("x_img", 0);

        // Diagonal image.
        send_frame(1);
        wait_drain();
        check_windows("diag_img", 1);

        // Backpressure on window 1.
        rdy_mode  = 2;
        win_ready = 1'b1;
        send_frame(0);
        @(posedge clk);
        #1;
        win_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk32("bp_hold_pixels", pixels, 32'hff0101ff);
            chk1("bp_hold_valid", win_valid, 1'b1);
            chk1("bp_hold_ready", pix_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
        wait_drain();
        check_windows("bp_img", 0);
        rdy_mode = 0;

        // Early start of frame after five pixels.
        e0 = err_seen;
        for (int i = 0; i < 5; i++) send_pix(8'($urandom), i == 0);
        send_frame(0);
        wait_drain();
        chk32("early_sof_err_pulses", 32'(err_seen - e0), 32'd1);
        check_windows("early_sof_img", 0);

        // Reset after two windows of an X frame.
        rdy_mode  = 2;
        win_ready = 1'b1;
        send_frame(0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        win_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_mid_valid", win_valid, 1'b0);
        @(negedge clk);
        chk1("rst_mid_ready", pix_ready, 1'b1);
        @(posedge clk);
        #1;
        rdy_mode  = 0;
        win_ready = 1'b1;
        got_q.delete();
        send_frame(0);
        wait_drain();
        check_windows("post_rst_img", 0);

        // Back-to-back X then O with pix_valid held high.
        send_frame(0);
        send_frame(2);
        wait_drain();
        check_windows("b2b_x_img", 0);
        check_windows("b2b_o_img", 2);

        // Random frames, random backpressure, occasional resets and early restarts.
        rdy_mode = 1;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                pulse_reset();
                repeat ($urandom_range(0, 2)) send_pix(8'($urandom), 1'b0);
            end
            if ($urandom_range(0, 4) == 0) begin
                cnt = $urandom_range(1, N - 1);
                for (int i = 0; i < cnt; i++) send_pix(8'($urandom), i == 0);
            end
            for (int i = 0; i < N; i++) begin
                send_pix(8'($urandom), (i == 0) ? ($urandom_range(0, 5) != 0) : 1'b0);
                repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            if ($urandom_range(0, 6) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk);
                    #1;
                end
                pulse_reset();
            end
        end
        wait_drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, required completion before %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
